// File: rtl/batcharger_pkg.sv
// batcharger_pkg: charger states, fault codes and default thresholds
package batcharger_pkg;
    typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_FAULT} state_t;
    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_TEMP = 2'd1;
    localparam logic [1:0] FC_TC   = 2'd2;
    localparam logic [1:0] FC_CHG  = 2'd3;
    localparam int ADC_W_DEF      = 10;
    localparam int SEL_W_DEF      = 4;
    localparam int IUNIT_DEF      = 10;
    localparam int VCUTOFF_DEF    = 600;
    localparam int VTARGET_DEF    = 840;
    localparam int VRECHARGE_DEF  = 800;
    localparam int TEMP_MIN_DEF   = 100;
    localparam int TEMP_MAX_DEF   = 900;
    localparam int IEND_SHIFT_DEF = 4;
    localparam int END_CNT_DEF    = 4;
    localparam int TC_MAX_DEF     = 1024;
    localparam int CHG_MAX_DEF    = 65535;
endpackage

// File: rtl/batcharger_if.sv
// batcharger_if: ADC sample bus in, DAC setpoints and status out
interface batcharger_if #(parameter int ADC_W = batcharger_pkg::ADC_W_DEF);
    logic             sample_valid;
    logic [ADC_W-1:0] vbat_code;
    logic [ADC_W-1:0] ibat_code;
    logic [ADC_W-1:0] vtemp_code;
    logic [ADC_W-1:0] iset_code;
    logic [ADC_W-1:0] vset_code;
    logic             tc;
    logic             cc;
    logic             cv;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    modport master (
        output sample_valid, vbat_code, ibat_code, vtemp_code,
        input  iset_code, vset_code, tc, cc, cv, done, fault, fault_code
    );
    modport slave (
        input  sample_valid, vbat_code, ibat_code, vtemp_code,
        output iset_code, vset_code, tc, cc, cv, done, fault, fault_code
    );
endinterface

// File: rtl/batcharger_setpoint.sv
// batcharger_setpoint: CC, trickle and end-of-charge currents from capacity select
module batcharger_setpoint
    import batcharger_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int IUNIT      = IUNIT_DEF,
    parameter int IEND_SHIFT = IEND_SHIFT_DEF
) (
    input  logic [SEL_W-1:0] sel,
    output logic [ADC_W-1:0] icc,
    output logic [ADC_W-1:0] itc,
    output logic [ADC_W-1:0] iend
);
    localparam int PW = ADC_W + SEL_W + 1;
    logic [PW-1:0] prod;
    always_comb begin
        prod = (PW'(sel) + PW'(1)) * PW'(IUNIT);
        icc  = |prod[PW-1:ADC_W] ? '1 : prod[ADC_W-1:0];
        itc  = icc >> 3;
        iend = icc >> IEND_SHIFT;
    end
endmodule

// File: rtl/batcharger_ctrl.sv
// batcharger_ctrl: TC/CC/CV charge FSM with recharge, temperature and timeout faults
module batcharger_ctrl
    import batcharger_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int IUNIT      = IUNIT_DEF,
    parameter int VCUTOFF    = VCUTOFF_DEF,
    parameter int VTARGET    = VTARGET_DEF,
    parameter int VRECHARGE  = VRECHARGE_DEF,
    parameter int TEMP_MIN   = TEMP_MIN_DEF,
    parameter int TEMP_MAX   = TEMP_MAX_DEF,
    parameter int IEND_SHIFT = IEND_SHIFT_DEF,
    parameter int END_CNT    = END_CNT_DEF,
    parameter int TC_MAX     = TC_MAX_DEF,
    parameter int CHG_MAX    = CHG_MAX_DEF
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic [SEL_W-1:0] sel,
    batcharger_if.slave     bus
);
    localparam int TCW = $clog2(TC_MAX + 1);
    localparam int CGW = $clog2(CHG_MAX + 1);
    localparam int ENW = $clog2(END_CNT + 1);
    state_t           state, state_n;
    logic [TCW-1:0]   tc_cnt, tc_cnt_n, tc_inc;
    logic [CGW-1:0]   chg_cnt, chg_cnt_n, chg_inc;
    logic [ENW-1:0]   end_cnt, end_cnt_n, end_inc;
    logic [1:0]       fc_n;
    logic [ADC_W-1:0] icc, itc, iend, iset_n, vset_n;
    logic             temp_bad, active;

    batcharger_setpoint #(
        .ADC_W(ADC_W), .SEL_W(SEL_W), .IUNIT(IUNIT), .IEND_SHIFT(IEND_SHIFT)
    ) u_setpoint (
        .sel(sel), .icc(icc), .itc(itc), .iend(iend)
    );

    always_comb begin
        tc_inc    = tc_cnt + TCW'(tc_cnt != TCW'(TC_MAX));
        chg_inc   = chg_cnt + CGW'(chg_cnt != CGW'(CHG_MAX));
        end_inc   = end_cnt + ENW'(end_cnt != ENW'(END_CNT));
        temp_bad  = bus.vtemp_code < ADC_W'(TEMP_MIN) || bus.vtemp_code > ADC_W'(TEMP_MAX);
        active    = state inside {S_TC, S_CC, S_CV};
        state_n   = state;
        tc_cnt_n  = tc_cnt;
        chg_cnt_n = chg_cnt;
        end_cnt_n = end_cnt;
        fc_n      = bus.fault_code;
        if (!en) begin
            state_n   = S_IDLE;
            tc_cnt_n  = '0;
            chg_cnt_n = '0;
            end_cnt_n = '0;
            fc_n      = FC_NONE;
        end else if (bus.sample_valid && state != S_FAULT) begin
            if (state == S_IDLE) begin
                state_n = temp_bad ? S_IDLE : (bus.vbat_code < ADC_W'(VCUTOFF) ? S_TC : S_CC);
            end else if (temp_bad) begin
                state_n = S_FAULT;
                fc_n    = FC_TEMP;
            end else begin
                chg_cnt_n = active ? chg_inc : chg_cnt;
                tc_cnt_n  = state == S_TC ? tc_inc : tc_cnt;
                end_cnt_n = (state == S_CV && bus.ibat_code <= iend) ? end_inc : '0;
                if (state == S_TC && tc_inc == TCW'(TC_MAX)) begin
                    state_n = S_FAULT;
                    fc_n    = FC_TC;
                end else if (active && chg_inc == CGW'(CHG_MAX)) begin
                    state_n = S_FAULT;
                    fc_n    = FC_CHG;
                end else if (state == S_TC && bus.vbat_code >= ADC_W'(VCUTOFF)) begin
                    state_n = S_CC;
                end else if (state == S_CC && bus.vbat_code >= ADC_W'(VTARGET)) begin
                    state_n = S_CV;
                end else if (state == S_CV && end_cnt_n == ENW'(END_CNT)) begin
                    state_n = S_DONE;
                end else if (state == S_DONE && bus.vbat_code < ADC_W'(VRECHARGE)) begin
                    state_n   = S_CC;
                    tc_cnt_n  = '0;
                    chg_cnt_n = '0;
                end
            end
        end
        iset_n = state_n == S_TC ? itc : (state_n inside {S_CC, S_CV} ? icc : '0);
        vset_n = state_n inside {S_TC, S_CC, S_CV} ? ADC_W'(VTARGET) : '0;
    end

    // iset follows sel only on a sample so a mid-charge sel change waits for the next strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            tc_cnt         <= '0;
            chg_cnt        <= '0;
            end_cnt        <= '0;
            bus.fault_code <= FC_NONE;
            bus.iset_code  <= '0;
            bus.vset_code  <= '0;
            bus.tc         <= 1'b0;
            bus.cc         <= 1'b0;
            bus.cv         <= 1'b0;
            bus.done       <= 1'b0;
            bus.fault      <= 1'b0;
        end else begin
            state          <= state_n;
            tc_cnt         <= tc_cnt_n;
            chg_cnt        <= chg_cnt_n;
            end_cnt        <= end_cnt_n;
            bus.fault_code <= fc_n;
            bus.vset_code  <= vset_n;
            bus.tc         <= state_n == S_TC;
            bus.cc         <= state_n == S_CC;
            bus.cv         <= state_n == S_CV;
            bus.done       <= state_n == S_DONE;
            bus.fault      <= state_n == S_FAULT;
            if (!en || bus.sample_valid) bus.iset_code <= iset_n;
        end
    end
endmodule

// File: tb/tb_batcharger_ctrl.sv
// tb_batcharger_ctrl: directed and random charge scenarios against a behavioural charger model
module tb_batcharger_ctrl;
    localparam int TCM = 8;
    localparam int CGM = 60;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] sel_a = 4'd0;
    logic [4:0] sel_b = 5'd0;
    int         vecs = 0;
    int         errs = 0;
    string      m = "IDLE";
    int         tcn = 0, chgn = 0, endn = 0, fcm = 0, msel = 0;
    logic [26:0] obs_a, obs_b;

    batcharger_if #(.ADC_W(10)) ifa ();
    batcharger_if #(.ADC_W(10)) ifb ();
    assign ifb.sample_valid = ifa.sample_valid;
    assign ifb.vbat_code    = ifa.vbat_code;
    assign ifb.ibat_code    = ifa.ibat_code;
    assign ifb.vtemp_code   = ifa.vtemp_code;
    assign obs_a = {ifa.iset_code, ifa.vset_code, ifa.tc, ifa.cc, ifa.cv, ifa.done, ifa.fault, ifa.fault_code};
    assign obs_b = {ifb.iset_code, ifb.vset_code, ifb.tc, ifb.cc, ifb.cv, ifb.done, ifb.fault, ifb.fault_code};

    batcharger_ctrl #(.TC_MAX(TCM), .CHG_MAX(CGM)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sel(sel_a), .bus(ifa.slave)
    );
    batcharger_ctrl #(.SEL_W(5), .IUNIT(40)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sel(sel_b), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    function automatic int icc_of(input int s);
        int v;
        v = (s + 1) * 10;
        return v > 1023 ? 1023 : v;
    endfunction

    function automatic void mdl_clear();
        m = "IDLE";
        tcn = 0;
        chgn = 0;
        endn = 0;
        fcm = 0;
    endfunction

    function automatic void mdl_sample(input int vb, input int ib, input int vt, input int s);
        bit hot, act;
        msel = s;
        hot = vt < 100 || vt > 900;
        if (m == "FAULT") return;
        if (m == "IDLE") begin
            if (!hot) begin
                if (vb < 600) m = "TC";
                else m = "CC";
            end
            return;
        end
        if (hot) begin
            m = "FAULT";
            fcm = 1;
            return;
        end
        act = m == "TC" || m == "CC" || m == "CV";
        if (act && chgn < CGM) chgn++;
        if (m == "TC" && tcn < TCM) tcn++;
        if (m == "CV" && ib <= icc_of(s) / 16) endn = endn < 4 ? endn + 1 : 4;
        else endn = 0;
        if (m == "TC" && tcn == TCM) begin
            m = "FAULT";
            fcm = 2;
        end else if (act && chgn == CGM) begin
            m = "FAULT";
            fcm = 3;
        end else if (m == "TC") begin
            if (vb >= 600) m = "CC";
        end else if (m == "CC") begin
            if (vb >= 840) m = "CV";
        end else if (m == "CV") begin
            if (endn == 4) m = "DONE";
        end else if (m == "DONE" && vb < 800) begin
            m = "CC";
            tcn = 0;
            chgn = 0;
        end
    endfunction

    function automatic logic [26:0] exp_a();
        int is, vs;
        is = m == "TC" ? icc_of(msel) / 8 : ((m == "CC" || m == "CV") ? icc_of(msel) : 0);
        vs = (m == "TC" || m == "CC" || m == "CV") ? 840 : 0;
        return {10'(is), 10'(vs), m == "TC", m == "CC", m == "CV", m == "DONE", m == "FAULT", 2'(fcm)};
    endfunction

    task automatic drive(input int vb, input int ib, input int vt);
        @(negedge clk);
        ifa.vbat_code = 10'(vb);
        ifa.ibat_code = 10'(ib);
        ifa.vtemp_code = 10'(vt);
        ifa.sample_valid = 1'b1;
        @(negedge clk);
        ifa.sample_valid = 1'b0;
        if (en) mdl_sample(vb, ib, vt, int'(sel_a));
        else mdl_clear();
    endtask

    task automatic en_pulse();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        mdl_clear();
    endtask

    task automatic test_reset();
        ifa.vbat_code = 10'd500;
        ifa.ibat_code = 10'd0;
        ifa.vtemp_code = 10'd500;
        ifa.sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if (obs_a !== 27'd0) begin errs++; $display("FAIL reset_a: got %h want %h", obs_a, 27'd0); end
        vecs++;
        if (obs_b !== 27'd0) begin errs++; $display("FAIL reset_b: got %h want %h", obs_b, 27'd0); end
        ifa.sample_valid = 1'b0;
        rst = 1'b0;
        mdl_clear();
        repeat (3) @(negedge clk);
        vecs++;
        if (obs_a !== exp_a()) begin errs++; $display("FAIL idle_hold: got %h want %h", obs_a, exp_a()); end
    endtask

    task automatic test_nominal();
        sel_a = 4'd8;
        drive(500, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.tc !== 1'b1 || ifa.iset_code !== 10'd11)
            begin errs++; $display("FAIL nominal_tc: got %h want %h", obs_a, exp_a()); end
        drive(600, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.cc !== 1'b1 || ifa.iset_code !== 10'd90)
            begin errs++; $display("FAIL nominal_cc: got %h want %h", obs_a, exp_a()); end
        drive(840, 50, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.cv !== 1'b1 || ifa.vset_code !== 10'd840)
            begin errs++; $display("FAIL nominal_cv: got %h want %h", obs_a, exp_a()); end
        for (int k = 0; k < 4; k++) begin
            drive(840, 5, 500);
            vecs++;
            if (obs_a !== exp_a()) begin errs++; $display("FAIL nominal_end%0d: got %h want %h", k, obs_a, exp_a()); end
        end
        vecs++;
        if (ifa.done !== 1'b1 || ifa.iset_code !== 10'd0)
            begin errs++; $display("FAIL nominal_done: got done=%b iset=%0d want done=1 iset=0", ifa.done, ifa.iset_code); end
    endtask

    task automatic test_recharge();
        drive(810, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.done !== 1'b1) begin errs++; $display("FAIL recharge_hold: got %h want %h", obs_a, exp_a()); end
        drive(799, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.cc !== 1'b1 || ifa.iset_code !== 10'd90)
            begin errs++; $display("FAIL recharge_cc: got %h want %h", obs_a, exp_a()); end
    endtask

    task automatic test_cv_end_reset();
        int seq[8] = '{5, 5, 5, 40, 5, 5, 5, 5};
        drive(840, 50, 500);
        for (int k = 0; k < 8; k++) begin
            drive(840, seq[k], 500);
            vecs++;
            if (obs_a !== exp_a() || ifa.done !== (k == 7))
                begin errs++; $display("FAIL cv_end%0d: got %h want %h", k, obs_a, exp_a()); end
        end
    endtask

    task automatic test_sel_hold();
        drive(790, 0, 500);
        sel_a = 4'd3;
        repeat (3) @(negedge clk);
        vecs++;
        if (obs_a !== exp_a() || ifa.iset_code !== 10'd90) begin errs++; $display("FAIL sel_hold: got %h want %h", obs_a, exp_a()); end
        drive(790, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.iset_code !== 10'd40) begin errs++; $display("FAIL sel_update: got %h want %h", obs_a, exp_a()); end
        sel_a = 4'd8;
    endtask

    task automatic test_temp_fault();
        en_pulse();
        drive(700, 0, 99);
        vecs++;
        if (obs_a !== exp_a() || obs_a !== 27'd0) begin errs++; $display("FAIL temp_idle_block: got %h want %h", obs_a, exp_a()); end
        drive(700, 0, 100);
        drive(700, 0, 900);
        vecs++;
        if (obs_a !== exp_a() || ifa.cc !== 1'b1) begin errs++; $display("FAIL temp_edge: got %h want %h", obs_a, exp_a()); end
        drive(700, 0, 950);
        vecs++;
        if (obs_a !== exp_a() || ifa.fault !== 1'b1 || ifa.fault_code !== 2'd1 || ifa.iset_code !== 10'd0)
            begin errs++; $display("FAIL temp_fault: got %h want %h", obs_a, exp_a()); end
        drive(700, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.fault !== 1'b1) begin errs++; $display("FAIL temp_sticky: got %h want %h", obs_a, exp_a()); end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        mdl_clear();
        vecs++;
        if (obs_a !== exp_a() || ifa.fault !== 1'b0) begin errs++; $display("FAIL temp_clear: got %h want %h", obs_a, exp_a()); end
        en = 1'b1;
    endtask

    task automatic test_tc_timeout();
        en_pulse();
        for (int k = 0; k < 9; k++) begin
            drive(500, 0, 500);
            vecs++;
            if (obs_a !== exp_a()) begin errs++; $display("FAIL tc_timeout%0d: got %h want %h", k, obs_a, exp_a()); end
        end
        vecs++;
        if (ifa.fault_code !== 2'd2) begin errs++; $display("FAIL tc_timeout_code: got %0d want 2", ifa.fault_code); end
    endtask

    task automatic test_total_timeout();
        en_pulse();
        drive(700, 0, 500);
        for (int k = 0; k < CGM; k++) begin
            drive(700, 0, 500);
            vecs++;
            if (obs_a !== exp_a()) begin errs++; $display("FAIL chg_timeout%0d: got %h want %h", k, obs_a, exp_a()); end
        end
        vecs++;
        if (ifa.fault_code !== 2'd3) begin errs++; $display("FAIL chg_timeout_code: got %0d want 3", ifa.fault_code); end
    endtask

    task automatic test_saturation();
        int sb[3] = '{31, 24, 25};
        int eb[3] = '{1023, 1000, 1023};
        en_pulse();
        for (int k = 0; k < 3; k++) begin
            sel_b = 5'(sb[k]);
            drive(700, 0, 500);
            vecs++;
            if (ifb.iset_code !== 10'(eb[k]) || ifb.cc !== 1'b1)
                begin errs++; $display("FAIL sat_sel%0d: got iset=%0d cc=%b want iset=%0d cc=1", sb[k], ifb.iset_code, ifb.cc, eb[k]); end
        end
    endtask

    task automatic test_rst_mid();
        en_pulse();
        drive(700, 0, 500);
        drive(840, 0, 500);
        vecs++;
        if (obs_a !== exp_a() || ifa.cv !== 1'b1) begin errs++; $display("FAIL rst_pre_cv: got %h want %h", obs_a, exp_a()); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_clear();
        vecs++;
        if (obs_a !== 27'd0) begin errs++; $display("FAIL rst_mid: got %h want %h", obs_a, 27'd0); end
    endtask

    task automatic test_random();
        int hot[4] = '{50, 99, 901, 990};
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 4) en_pulse();
            if ($urandom_range(0, 9) == 0) sel_a = 4'($urandom_range(0, 15));
            drive($urandom_range(450, 900), $urandom_range(0, 20),
                  $urandom_range(0, 99) < 6 ? hot[$urandom_range(0, 3)] : $urandom_range(100, 900));
            vecs++;
            if (obs_a !== exp_a()) begin errs++; $display("FAIL random%0d: got %h want %h", k, obs_a, exp_a()); end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                sel_a = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        ifa.sample_valid = 1'b0;
        test_reset();
        test_nominal();
        test_recharge();
        test_cv_end_reset();
        test_sel_hold();
        test_temp_fault();
        test_tc_timeout();
        test_total_timeout();
        test_saturation();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
